mac_axis_accum: RTL and testbench
=================================

# mac_axis_accum

Parametrised AXI4-Stream multiply-accumulate unit: the next-generation MAC for the neuromorphic coprocessor datapath. It consumes packed {weight, data} beats and accumulates their products over a frame delimited by `s_axis_tlast`. On each frame end it emits one saturated result with status flags on an output register. It supports signed or unsigned operands and full ready/valid backpressure, and it sits between the weight/activation streamer and the neuron threshold stage.

## Interface
Parameters:
- `DATA_W`, 8: activation operand width.
- `WEIGHT_W`, 8: weight operand width.
- `ACC_W`, 24: internal accumulator width; must be ≥ `DATA_W+WEIGHT_W`.
- `OUT_W`, 16: result width; must be ≤ `ACC_W`.
- `SIGNED`, 1: 1 means two's-complement operands and result; 0 means unsigned.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: accept enable; when 0, `s_axis_tready`=0.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input beat ready.
- `s_axis_tdata` in `WEIGHT_W+DATA_W`: packed {weight[MSBs], data[LSBs]}.
- `s_axis_tlast` in 1: marks the final beat of a dot-product frame.
- `m_axis_tvalid` out 1: result valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out `OUT_W`: accumulated, saturated result.
- `m_axis_tuser` out 2: bit0 = output saturated; bit1 = accumulator wrapped during the frame.

## Operation
- Input handshake: a beat is accepted when `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready = en && (!m_axis_tvalid || m_axis_tready)`. This is combinational from registered state and `m_axis_tready`.
- Product: `data*weight`, signed or unsigned per `SIGNED`, sign- or zero-extended to `ACC_W`.
- Non-last accepted beat: `acc <= acc + product`. If the `ACC_W` addition overflows, it wraps and sets the sticky `wrap` flag.
- Last accepted beat:
  - Compute `sum = acc + product` and `wrap` including this beat.
  - Saturate `sum` to `OUT_W`. Signed range is [-2^(OUT_W-1), 2^(OUT_W-1)-1]; unsigned range is [0, 2^OUT_W-1].
  - Load `m_axis_tdata`, `m_axis_tuser` = {wrap, sat}, and set `m_axis_tvalid`=1.
  - Clear `acc` and `wrap` in the same cycle; the next frame starts from 0.
- Output register holds data stable while `m_axis_tvalid && !m_axis_tready`.
- Output transfer (`m_axis_tvalid && m_axis_tready`) clears `m_axis_tvalid` unless a new last beat is accepted the same cycle. In that case the output reloads and valid stays 1, giving full throughput.
- Single-beat frame (tlast on the first beat): result equals the saturated product.
- `en` deasserted mid-frame pauses acceptance only; the partial `acc` is retained.
- State summary: ACCUM (`m_axis_tvalid`=0), HOLD (`m_axis_tvalid`=1).
  - ACCUM→HOLD on an accepted last beat.
  - HOLD→ACCUM on an output transfer with no new last beat.
  - HOLD→HOLD while stalled, or on transfer plus a new last beat.

## Timing
- Reset values (asynchronous, immediate): `acc`=0, `wrap`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0. `s_axis_tready` follows its equation, so it is high after reset whenever `en`=1.
- Latency: the result is valid the cycle after the last beat is accepted (1 cycle).
- Throughput: 1 beat per cycle sustained, including back-to-back single-beat frames while `m_axis_tready`=1.
- Reset asserted mid-frame or mid-HOLD discards the partial sum and any pending result; no output is produced for that frame.
- `m_axis_tvalid` never depends combinationally on `m_axis_tready`.

## Structure
- Shared package `mac_pkg`:
  - `SAT_FLAG`/`WRAP_FLAG` bit indices.
  - Saturation helper function parametrised on signedness.
- One natural sub-module, `mac_sat`: combinational `ACC_W`→`OUT_W` saturator with a `sat` output. It is reused by the downstream threshold stage.
- Top contains the accumulator, wrap detection, output register and handshake.

## Test plan
- Unsigned (`SIGNED`=0), frame {3×4, 5×6, 2×10 last}, ready=1 → one result 62, tuser=0, one cycle after the last beat.
- Signed, frame {-2×7, 3×3 last} → result -5 (0xFFFB for `OUT_W`=16), tuser=0.
- Signed, `OUT_W`=16, 3 beats of 127×127 → saturates to 32767, tuser=01. A following frame {1×1 last} → 1 (acc cleared).
- Backpressure: hold `m_axis_tready`=0 for 5 cycles with the result pending. Expect `s_axis_tready`=0, tdata stable and no beats lost. Release → transfer, then acceptance resumes.
- Back-to-back single-beat frames 2×2, 3×3, 4×4 with ready=1 → outputs 4, 9, 16 on consecutive cycles with valid continuously high.
- Reset asserted mid-frame after {10×10} → no output. The post-reset frame {1×2 last} yields 2.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: status flag positions, FSM states
// and a width-agnostic saturation helper shared with the threshold stage.
package mac_pkg;

    localparam int SAT_FLAG  = 0;
    localparam int WRAP_FLAG = 1;
    localparam int SAT_EXT_W = 64;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } mac_state_e;

    // Clamp an already sign/zero-extended value to out_w bits; MSB of the
    // return value is the "saturated" flag, the rest is the clamped value.
    function automatic logic [SAT_EXT_W:0] saturate(
        input logic [SAT_EXT_W-1:0] val,
        input int                   out_w,
        input bit                   is_signed
    );
        logic signed [SAT_EXT_W-1:0] smax;
        logic signed [SAT_EXT_W-1:0] smin;
        logic        [SAT_EXT_W-1:0] umax;
        logic        [SAT_EXT_W:0]   res;
        smax = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (out_w - 1));
        umax = (64'd1 << out_w) - 64'd1;
        res  = {1'b0, val};
        if (is_signed) begin
            if ($signed(val) > smax) begin
                res = {1'b1, smax};
            end else if ($signed(val) < smin) begin
                res = {1'b1, smin};
            end
        end else if (val > umax) begin
            res = {1'b1, umax};
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational ACC_W -> OUT_W saturator with a flag showing the value was clamped.
module mac_sat
    import mac_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 1
) (
    input  logic [ACC_W-1:0] acc_in,
    output logic [OUT_W-1:0] sat_out,
    output logic             sat
);

    logic [SAT_EXT_W-1:0] ext;
    logic [SAT_EXT_W:0]   res;

    always_comb begin
        if (SIGNED != 0) begin
            ext = {{(SAT_EXT_W-ACC_W){acc_in[ACC_W-1]}}, acc_in};
        end else begin
            ext = {{(SAT_EXT_W-ACC_W){1'b0}}, acc_in};
        end
        res     = saturate(ext, OUT_W, SIGNED != 0);
        sat_out = res[OUT_W-1:0];
        sat     = res[SAT_EXT_W];
    end

endmodule

// File: rtl/mac_axis_accum.sv
// AXI4-Stream multiply-accumulate: sums weight*data over a tlast-delimited frame
// and emits one saturated result with {wrap, sat} status per frame.
module mac_axis_accum
    import mac_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16,
    parameter int SIGNED   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [WEIGHT_W+DATA_W-1:0] s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [OUT_W-1:0]           m_axis_tdata,
    output logic [1:0]                 m_axis_tuser
);

    localparam int PROD_W = DATA_W + WEIGHT_W;

    mac_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              wrap_q, wrap_d;
    logic [OUT_W-1:0]  tdata_q, tdata_d;
    logic [1:0]        tuser_q, tuser_d;

    logic [DATA_W-1:0]        data_in;
    logic [WEIGHT_W-1:0]      weight_in;
    logic signed [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0]        prod_u;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W:0]           sum_ext;
    logic [ACC_W-1:0]         sum;
    logic                     ovf;
    logic [OUT_W-1:0]         sat_val;
    logic                     sat_flag;
    logic                     accept;
    logic                     last_accept;

    assign data_in   = s_axis_tdata[DATA_W-1:0];
    assign weight_in = s_axis_tdata[PROD_W-1:DATA_W];

    // Product and ACC_W-wide sum with overflow detection for either signedness.
    always_comb begin
        prod_s = PROD_W'($signed(data_in)) * PROD_W'($signed(weight_in));
        prod_u = PROD_W'(data_in) * PROD_W'(weight_in);
        if (SIGNED != 0) begin
            prod_ext = ACC_W'(prod_s);
        end else begin
            prod_ext = ACC_W'(prod_u);
        end
        sum_ext = {1'b0, acc_q} + {1'b0, prod_ext};
        sum     = sum_ext[ACC_W-1:0];
        if (SIGNED != 0) begin
            ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            ovf = sum_ext[ACC_W];
        end
    end

    mac_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SIGNED(SIGNED)
    ) u_sat (
        .acc_in (sum),
        .sat_out(sat_val),
        .sat    (sat_flag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            wrap_q  <= 1'b0;
            tdata_q <= '0;
            tuser_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wrap_q  <= wrap_d;
            tdata_q <= tdata_d;
            tuser_q <= tuser_d;
        end
    end

    // Next state and datapath; a last beat both loads the output and restarts the sum.
    always_comb begin
        accept      = s_axis_tvalid && s_axis_tready;
        last_accept = accept && s_axis_tlast;
        state_d     = state_q;
        acc_d       = acc_q;
        wrap_d      = wrap_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        case (state_q)
            ST_ACCUM: if (last_accept) state_d = ST_HOLD;
            ST_HOLD:  if (!last_accept && m_axis_tready) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
        if (accept) begin
            if (s_axis_tlast) begin
                acc_d              = '0;
                wrap_d             = 1'b0;
                tdata_d            = sat_val;
                tuser_d[SAT_FLAG]  = sat_flag;
                tuser_d[WRAP_FLAG] = wrap_q || ovf;
            end else begin
                acc_d  = sum;
                wrap_d = wrap_q || ovf;
            end
        end
    end

    always_comb begin
        m_axis_tvalid = (state_q == ST_HOLD);
        s_axis_tready = en && (!m_axis_tvalid || m_axis_tready);
        m_axis_tdata  = tdata_q;
        m_axis_tuser  = tuser_q;
    end

endmodule

// File: tb/tb_mac_axis_accum.sv
// Randomised + directed bench for mac_axis_accum (signed, 8x8 -> 24-bit acc -> 16-bit out)
// with a queue scoreboard fed by an arithmetic reference model.
module tb_mac_axis_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] m_tdata;
    logic [1:0]  m_tuser;

    mac_axis_accum #(
        .DATA_W  (8),
        .WEIGHT_W(8),
        .ACC_W   (24),
        .OUT_W   (16),
        .SIGNED  (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata (s_tdata),
        .s_axis_tlast (s_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tuser (m_tuser)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  user;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint acc_m = 0;
    bit     wrap_m = 1'b0;

    bit rand_mode   = 1'b0;
    bit ready_fixed = 1'b1;
    bit en_fixed    = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true integer sum folded into the 24-bit two's-complement range,
    // clamped to 16-bit signed at frame end.
    task automatic model_beat(input int w, input int d, input bit last);
        longint r;
        bit     s;
        exp_t   e;
        acc_m = acc_m + longint'(w) * longint'(d);
        if (acc_m > 64'sd8388607) begin
            acc_m  = acc_m - 64'sd16777216;
            wrap_m = 1'b1;
        end else if (acc_m < -64'sd8388608) begin
            acc_m  = acc_m + 64'sd16777216;
            wrap_m = 1'b1;
        end
        if (last) begin
            r = acc_m;
            s = 1'b0;
            if (r > 32767) begin
                r = 32767;
                s = 1'b1;
            end else if (r < -32768) begin
                r = -32768;
                s = 1'b1;
            end
            e.data = r[15:0];
            e.user = {wrap_m, s};
            exp_q.push_back(e);
            acc_m  = 0;
            wrap_m = 1'b0;
        end
    endtask

    // Downstream ready / enable driver.
    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            m_tready = ($urandom_range(0, 9) < 7);
            en       = ($urandom_range(0, 9) < 8);
        end else begin
            m_tready = ready_fixed;
            en       = en_fixed;
        end
    end

    // Monitor: protocol checks, output scoreboard, model update on accepted beats.
    bit          last_prev = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] held_data;
    logic [1:0]  held_user;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_prev  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("s_ready_eq", {31'd0, s_tready}, {31'd0, en && (!m_tvalid || m_tready)});
            if (last_prev) check("latency_valid", {31'd0, m_tvalid}, 32'd1);
            if (stall_prev) begin
                check("hold_valid", {31'd0, m_tvalid}, 32'd1);
                check("hold_data", {16'd0, m_tdata}, {16'd0, held_data});
                check("hold_user", {30'd0, m_tuser}, {30'd0, held_user});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected none at %0t", m_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {16'd0, m_tdata}, {16'd0, e.data});
                    check("out_user", {30'd0, m_tuser}, {30'd0, e.user});
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_user  = m_tuser;
            last_prev  = s_tvalid && s_tready && s_tlast;
            if (s_tvalid && s_tready)
                model_beat(int'($signed(s_tdata[15:8])), int'($signed(s_tdata[7:0])), s_tlast);
        end
    end

    task automatic send(input int w, input int d, input bit last);
        bit ok;
        int cyc;
        s_tdata  = {w[7:0], d[7:0]};
        s_tlast  = last;
        s_tvalid = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            ok = s_tready && !reset;
            @(posedge clk);
            #1;
            if (ok) break;
            cyc++;
            if (cyc > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got no ready expected accept at %0t", $time);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_valid", {31'd0, m_tvalid}, 32'd0);
        check("rst_data", {16'd0, m_tdata}, 32'd0);
        check("rst_user", {30'd0, m_tuser}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #2 check_reset_values();
        exp_q.delete();
        acc_m  = 0;
        wrap_m = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check_reset_values();
        check("rst_s_ready", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);

        // Small mixed frame, then a negative result
        send(4, 3, 0); send(6, 5, 0); send(10, 2, 1);
        idle(2);
        send(7, -2, 0); send(3, 3, 1);
        idle(2);

        // Positive saturation, then a fresh frame from zero
        send(127, 127, 0); send(127, 127, 0); send(127, 127, 1);
        send(1, 1, 1);
        idle(2);

        // Backpressure: result pending for 5 cycles while a new last beat waits
        ready_fixed = 1'b0;
        idle(1);
        send(5, 5, 1);
        fork
            send(6, 6, 1);
            begin
                repeat (5) @(posedge clk);
                ready_fixed = 1'b1;
            end
        join
        idle(3);

        // Back-to-back single-beat frames
        send(2, 2, 1); send(3, 3, 1); send(4, 4, 1);
        idle(2);

        // Reset mid-frame discards the partial sum
        send(10, 10, 0);
        do_reset();
        send(2, 1, 1);
        idle(2);

        // Accumulator wrap: 520 x (-128*-128) overflows 24 bits, then clamps low
        for (int i = 0; i < 520; i++) send(-128, -128, (i == 519));
        idle(2);

        // Randomised frames with random ready/enable and gaps
        rand_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, (b == len - 1));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rand_mode = 1'b0;
        idle(10);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
